// File: rtl/serdes_rx_pkg.sv
// Shared receive-path definitions: symbol width, K28.5 encodings, aligner states.
// Latency: n/a (types, constants and pure combinational helpers only).
// Backpressure: n/a.
package serdes_rx_pkg;

    localparam int SYMBOL_WIDTH = 10;
    localparam int WINDOW_WIDTH = 2 * SYMBOL_WIDTH;

    // K28.5 in both running disparities, bit a in the MSB.
    localparam logic [SYMBOL_WIDTH-1:0] K28_5_RDN = 10'b0011111010;
    localparam logic [SYMBOL_WIDTH-1:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } align_state_t;

    function automatic logic is_comma(input logic [SYMBOL_WIDTH-1:0] sym);
        return (sym == K28_5_RDN) || (sym == K28_5_RDP);
    endfunction

    // Candidate symbol at offset k of the window: win[19-k -: 10].
    // Expressed as a right shift so the offset can be a run-time value; k is
    // always 0..9, so the shift amount stays within 1..10.
    function automatic logic [SYMBOL_WIDTH-1:0] window_slice(
        input logic [WINDOW_WIDTH-1:0] win,
        input logic [3:0]              k
    );
        return SYMBOL_WIDTH'(win >> (4'(SYMBOL_WIDTH) - k));
    endfunction

endpackage

// File: rtl/comma_detector.sv
// Purpose: find K28.5 (either disparity) in a 20-bit sliding window; lowest offset wins.
// Latency: purely combinational. Backpressure: none.
// Ports: window (in, {prev_word, data_in}), found (out), offset (out, 0..9, valid with found).
module comma_detector
    import serdes_rx_pkg::*;
(
    input  logic [WINDOW_WIDTH-1:0] window,
    output logic                    found,
    output logic [3:0]              offset
);

    // Scan from the highest offset down so the lowest matching offset is the
    // last assignment and therefore the one that sticks.
    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int k = SYMBOL_WIDTH - 1; k >= 0; k--) begin
            if (is_comma(window_slice(window, 4'(k)))) begin
                found  = 1'b1;
                offset = 4'(k);
            end
        end
    end

endmodule

// File: rtl/comma_aligner.sv
// Purpose: lock the 10b symbol boundary on repeated K28.5 at one offset, emit aligned symbols.
// Latency: 1 cycle data_in->data_out for offsets 1..9, 2 cycles at offset 0; lock 1 cycle after last comma.
// Backpressure: none, one symbol per clock; data_valid gates the downstream elastic buffer write.
// Ports: recovered_clock, recovered_reset (async, active-low), data_in[9:0] (data_in[9] earliest bit),
//        data_out[9:0] (bit a in MSB), data_valid, locked, comma_detected (pulse), bit_offset[3:0].
module comma_aligner
    import serdes_rx_pkg::*;
#(
    parameter int LOCK_COUNT   = 3,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic                    recovered_clock,
    input  logic                    recovered_reset,
    input  logic [SYMBOL_WIDTH-1:0] data_in,
    output logic [SYMBOL_WIDTH-1:0] data_out,
    output logic                    data_valid,
    output logic                    locked,
    output logic                    comma_detected,
    output logic [3:0]              bit_offset
);

    localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LOCK_CNT_V   = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] UNLOCK_CNT_V = CNT_W'(UNLOCK_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    align_state_t              state;
    align_state_t              state_nxt;
    logic [SYMBOL_WIDTH-1:0]   prev_word;
    logic [CNT_W-1:0]          match_cnt;
    logic [CNT_W-1:0]          miss_cnt;

    logic [WINDOW_WIDTH-1:0]   window;
    logic                      found;
    logic [3:0]                found_off;
    logic                      on_offset;
    logic [CNT_W-1:0]          match_inc;
    logic [CNT_W-1:0]          miss_inc;
    logic [3:0]                sel_offset;
    logic [SYMBOL_WIDTH-1:0]   sel_sym;

    // Counters hold at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    assign window = {prev_word, data_in};

    comma_detector u_detector (
        .window (window),
        .found  (found),
        .offset (found_off)
    );

    assign on_offset = found && (found_off == bit_offset);
    assign match_inc = sat_inc(match_cnt);
    assign miss_inc  = sat_inc(miss_cnt);

    // Offset that will be in force after this edge. Outside LOCKED a comma
    // re-targets the offset immediately, so the symbol registered alongside
    // the (possibly lock-completing) comma is the comma itself.
    assign sel_offset = (found && (state != LOCKED)) ? found_off : bit_offset;
    assign sel_sym    = window_slice(window, sel_offset);

    always_comb begin
        state_nxt = state;
        if (found) begin
            case (state)
                SEARCH: begin
                    state_nxt = (LOCK_COUNT <= 1) ? LOCKED : CONFIRM;
                end
                CONFIRM: begin
                    if (on_offset && (match_inc >= LOCK_CNT_V)) begin
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (!on_offset && (miss_inc >= UNLOCK_CNT_V)) begin
                        state_nxt = SEARCH;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge recovered_clock or negedge recovered_reset) begin
        if (!recovered_reset) begin
            state          <= SEARCH;
            prev_word      <= '0;
            match_cnt      <= '0;
            miss_cnt       <= '0;
            bit_offset     <= '0;
            data_out       <= '0;
            data_valid     <= 1'b0;
            locked         <= 1'b0;
            comma_detected <= 1'b0;
        end else begin
            prev_word  <= data_in;
            state      <= state_nxt;
            bit_offset <= sel_offset;
            data_out   <= sel_sym;

            // Status follows the post-edge state so it lines up with data_out.
            locked         <= (state_nxt == LOCKED);
            data_valid     <= (state_nxt == LOCKED);
            comma_detected <= (state_nxt == LOCKED) && is_comma(sel_sym);

            if (found) begin
                case (state)
                    SEARCH: begin
                        match_cnt <= CNT_ONE;
                        miss_cnt  <= '0;
                    end
                    CONFIRM: begin
                        // A comma elsewhere restarts the confirmation at the new offset.
                        match_cnt <= on_offset ? match_inc : CNT_ONE;
                    end
                    LOCKED: begin
                        if (on_offset) begin
                            miss_cnt <= '0;
                        end else if (miss_inc >= UNLOCK_CNT_V) begin
                            // Drop lock; bit_offset is deliberately left as is.
                            match_cnt <= '0;
                            miss_cnt  <= '0;
                        end else begin
                            miss_cnt <= miss_inc;
                        end
                    end
                    default: begin
                        match_cnt <= '0;
                        miss_cnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_comma_aligner.sv
module tb_comma_aligner;
    import serdes_rx_pkg::*;

    typedef struct { int start; logic [9:0] val; } sym_t;
    typedef struct { int edge_n; logic [9:0] val; } exp_t;
    typedef struct { int edge_n; logic [3:0] off; } ochk_t;
    typedef struct { int off; int mode; int gap; logic [3:0] exp_off; } case_t;

    localparam int NEVER = 1 << 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [9:0] data_in = '0;
    logic [9:0] data_out;
    logic       data_valid;
    logic       locked;
    logic       comma_detected;
    logic [3:0] bit_offset;

    int total = 0;
    int bad = 0;

    bit    bits_q[$];
    sym_t  sym_q[$];
    exp_t  sb_q[$];
    ochk_t ochk_q[$];

    always #5 clk = ~clk;

    comma_aligner #(.LOCK_COUNT(3), .UNLOCK_COUNT(4)) dut (
        .recovered_clock (clk),
        .recovered_reset (rst_n),
        .data_in         (data_in),
        .data_out        (data_out),
        .data_valid      (data_valid),
        .locked          (locked),
        .comma_detected  (comma_detected),
        .bit_offset      (bit_offset)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- bit-stream construction ----------------
    function automatic int add_sym(input logic [9:0] v);
        sym_t s;
        int   p;
        p = bits_q.size();
        s.start = p;
        s.val = v;
        sym_q.push_back(s);
        for (int i = 9; i >= 0; i--) bits_q.push_back(v[i]);
        return p;
    endfunction

    // Alternating pad bits never form a run long enough to fake a comma.
    function automatic void pad_bit();
        if (bits_q.size() == 0) bits_q.push_back(1'b1);
        else bits_q.push_back(~bits_q[bits_q.size()-1]);
    endfunction

    function automatic void align_to(input int k);
        while ((bits_q.size() % 10) != k) pad_bit();
    endfunction

    function automatic logic [9:0] fill_sym(input int i);
        case (i % 4)
            0: return 10'h2AA;
            1: return 10'h155;
            2: return 10'h2D2;
            default: return 10'h1B4;
        endcase
    endfunction

    // mode 0: RD-, 1: RD+, 2: alternate starting with RD+
    function automatic logic [9:0] comma_for(input int mode, input int idx);
        if (mode == 0) return 10'h0FA;
        if (mode == 1) return 10'h305;
        return (idx % 2 == 0) ? 10'h305 : 10'h0FA;
    endfunction

    function automatic void push_ochk(input int e, input logic [3:0] off);
        ochk_t o;
        o.edge_n = e;
        o.off = off;
        ochk_q.push_back(o);
    endfunction

    task automatic reset_dut();
        data_in = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Drives the built stream one word per clock. A symbol starting at stream
    // bit p is visible on data_out after edge p/10+1 when aligned. Locked is
    // expected high after edges lock_e .. unlock_e-1.
    task automatic run_stream(input bit do_reset, input int exp_off, input int lock_e,
                              input int unlock_e, input string tag);
        int         nwords;
        exp_t       e;
        ochk_t      o;
        logic [9:0] w;
        logic       exp_lk;
        logic       exp_cd;
        align_to(0);
        repeat (20) pad_bit();
        nwords = bits_q.size() / 10;
        foreach (sym_q[i]) begin
            if ((sym_q[i].start % 10) == exp_off) begin
                e.edge_n = sym_q[i].start / 10 + 1;
                e.val = sym_q[i].val;
                if (e.edge_n >= lock_e && e.edge_n < unlock_e) sb_q.push_back(e);
            end
        end
        if (do_reset) reset_dut();
        for (int n = 0; n < nwords; n++) begin
            for (int i = 0; i < 10; i++) w[9-i] = bits_q[10*n + i];
            data_in = w;
            @(posedge clk);
            #1;
            exp_lk = (n >= lock_e) && (n < unlock_e);
            check({tag, "/locked"}, 32'(locked), 32'(exp_lk));
            check({tag, "/data_valid"}, 32'(data_valid), 32'(exp_lk));
            exp_cd = 1'b0;
            if (sb_q.size() > 0 && sb_q[0].edge_n == n) begin
                e = sb_q.pop_front();
                exp_cd = (e.val == K28_5_RDN) || (e.val == K28_5_RDP);
                check({tag, "/data_out"}, 32'(data_out), 32'(e.val));
            end
            check({tag, "/comma_detected"}, 32'(comma_detected), 32'(exp_cd));
            if (ochk_q.size() > 0 && ochk_q[0].edge_n == n) begin
                o = ochk_q.pop_front();
                check({tag, "/bit_offset"}, 32'(bit_offset), 32'(o.off));
            end
        end
        check({tag, "/scoreboard_left"}, 32'(sb_q.size()), 32'd0);
        check({tag, "/offset_checks_left"}, 32'(ochk_q.size()), 32'd0);
        bits_q.delete();
        sym_q.delete();
        sb_q.delete();
        ochk_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        case_t cases[4];
        int    p;
        int    le;
        int    e2;
        int    e3;
        int    u;

        cases[0] = '{off: 3, mode: 0, gap: 7, exp_off: 4'd3};
        cases[1] = '{off: 0, mode: 2, gap: 3, exp_off: 4'd0};
        cases[2] = '{off: 9, mode: 1, gap: 1, exp_off: 4'd9};
        cases[3] = '{off: 6, mode: 2, gap: 0, exp_off: 4'd6};

        // ---- reset and idle ----
        #1 rst_n = 1'b0;
        data_in = '0;
        #12;
        check("reset/data_out", 32'(data_out), 32'd0);
        check("reset/data_valid", 32'(data_valid), 32'd0);
        check("reset/locked", 32'(locked), 32'd0);
        check("reset/comma_detected", 32'(comma_detected), 32'd0);
        check("reset/bit_offset", 32'(bit_offset), 32'd0);
        check("reset/state", 32'(dut.state), 32'(SEARCH));
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            check("idle/data_valid", 32'(data_valid), 32'd0);
            check("idle/data_out", 32'(data_out), 32'd0);
        end
        check("idle/locked", 32'(locked), 32'd0);
        check("idle/state", 32'(dut.state), 32'(SEARCH));

        // ---- table-driven lock acquisition ----
        for (int i = 0; i < 4; i++) begin
            le = NEVER;
            align_to(cases[i].off);
            for (int c = 0; c < 5; c++) begin
                p = add_sym(comma_for(cases[i].mode, c));
                if (c == 2) le = p / 10 + 1;
                for (int g = 0; g < cases[i].gap; g++) void'(add_sym(fill_sym(g + c)));
            end
            repeat (3) void'(add_sym(fill_sym(1)));
            push_ochk(le, cases[i].exp_off);
            run_stream(1'b1, cases[i].off, le, NEVER, $sformatf("lock%0d", i));
        end

        // ---- CONFIRM: offset change restarts the count ----
        align_to(5);
        void'(add_sym(10'h0FA));
        void'(add_sym(fill_sym(0)));
        p = add_sym(10'h305);
        e2 = p / 10 + 1;
        void'(add_sym(fill_sym(1)));
        align_to(7);
        p = add_sym(10'h0FA);
        e3 = p / 10 + 1;
        void'(add_sym(fill_sym(2)));
        void'(add_sym(10'h0FA));
        void'(add_sym(fill_sym(3)));
        p = add_sym(10'h305);
        le = p / 10 + 1;
        repeat (2) void'(add_sym(fill_sym(0)));
        push_ochk(e2, 4'd5);
        push_ochk(e3, 4'd7);
        push_ochk(le, 4'd7);
        run_stream(1'b1, 7, le, NEVER, "confirm");

        // ---- LOCKED: foreign commas, miss counter cleared, then unlock ----
        align_to(2);
        for (int c = 0; c < 3; c++) begin
            p = add_sym(10'h0FA);
            if (c == 2) le = p / 10 + 1;
            void'(add_sym(fill_sym(c)));
            void'(add_sym(fill_sym(c + 1)));
        end
        align_to(6);
        for (int c = 0; c < 3; c++) begin
            void'(add_sym(10'h305));
            void'(add_sym(fill_sym(c)));
        end
        align_to(2);
        void'(add_sym(10'h0FA));
        void'(add_sym(fill_sym(2)));
        align_to(6);
        for (int c = 0; c < 3; c++) begin
            p = add_sym(10'h0FA);
            void'(add_sym(fill_sym(c)));
        end
        e3 = p / 10 + 1;
        p = add_sym(10'h305);
        u = p / 10 + 1;
        repeat (3) void'(add_sym(fill_sym(3)));
        push_ochk(le, 4'd2);
        push_ochk(e3, 4'd2);
        push_ochk(u, 4'd2);
        push_ochk(u + 2, 4'd2);
        run_stream(1'b1, 2, le, u, "unlock");
        check("unlock/state", 32'(dut.state), 32'(SEARCH));

        // ---- asynchronous reset while locked, then relock ----
        align_to(4);
        for (int c = 0; c < 3; c++) begin
            p = add_sym(10'h0FA);
            if (c == 2) le = p / 10 + 1;
            void'(add_sym(fill_sym(c)));
        end
        push_ochk(le, 4'd4);
        run_stream(1'b1, 4, le, NEVER, "prelock");
        check("midreset/locked_before", 32'(locked), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset/data_valid", 32'(data_valid), 32'd0);
        check("midreset/locked", 32'(locked), 32'd0);
        check("midreset/data_out", 32'(data_out), 32'd0);
        check("midreset/bit_offset", 32'(bit_offset), 32'd0);
        check("midreset/comma_detected", 32'(comma_detected), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        align_to(8);
        for (int c = 0; c < 3; c++) begin
            p = add_sym(10'h305);
            if (c == 2) le = p / 10 + 1;
            void'(add_sym(fill_sym(c)));
        end
        push_ochk(le, 4'd8);
        run_stream(1'b0, 8, le, NEVER, "relock");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
